// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// Shared instruction-set opcodes, idle ALU opcode and issue-controller state encoding.
package alu_issue_ctrl_pkg;

   localparam int NUM_REGS_DEF = 8;
   localparam int DATA_W_DEF   = 16;

   localparam logic [4:0] OP_ADD  = 5'h00;
   localparam logic [4:0] OP_ADC  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_INC  = 5'h03;
   localparam logic [4:0] OP_DEC  = 5'h04;
   localparam logic [4:0] OP_AND  = 5'h05;
   localparam logic [4:0] OP_OR   = 5'h06;
   localparam logic [4:0] OP_XOR  = 5'h07;
   localparam logic [4:0] OP_NOT  = 5'h08;
   // Outside the instruction set: the ALU keeps its result register unchanged.
   localparam logic [4:0] OP_HOLD = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RESULT = 2'd2,
      ST_FLAGS  = 2'd3
   } state_t;

   function automatic logic op_is_legal(input logic [4:0] op);
      return op inside {OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC,
                        OP_AND, OP_OR, OP_XOR, OP_NOT};
   endfunction

   function automatic logic op_is_arith(input logic [4:0] op);
      return op inside {OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC};
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// Register file: async-reset array, one write port, three combinational read ports.
module alu_regfile #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 16,
   localparam int ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign ra_data  = mem[ra_addr];
   assign rb_data  = mem[rb_addr];
   assign dbg_data = mem[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ALU issue controller: accepts one instruction, drives the ALU, writes back and holds flags.
// Optional macro ALU_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int         NUM_REGS = NUM_REGS_DEF,
   parameter int         DATA_W   = DATA_W_DEF,
   parameter logic [4:0] HOLD_OP  = OP_HOLD,
   localparam int        ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [4:0]        instr_op,
   input  logic [ADDR_W-1:0] instr_rd,
   input  logic [ADDR_W-1:0] instr_ra,
   input  logic [ADDR_W-1:0] instr_rb,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              alu_enable,
   output logic [4:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              alu_sign,
   output logic              flag_c,
   output logic              flag_z,
   output logic              flag_s,
   output logic              done,
   output logic              illegal_op,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
`ifdef ALU_RETIRE_CNT_EN
   ,
   output logic [15:0]       retire_cnt
`endif
);

   state_t            state;
   state_t            state_nx;
   logic [4:0]        op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] result_q;
   logic [DATA_W-1:0] ra_data;
   logic [DATA_W-1:0] rb_data;
   logic              accept;
   logic              legal;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   assign instr_ready = (state == ST_IDLE) && !rst;
   assign accept      = instr_valid && instr_ready;
   assign legal       = op_is_legal(instr_op);
   assign alu_enable  = (state == ST_ISSUE);
   assign done        = (state == ST_FLAGS);

   // Writeback owns the single write port; a load only lands in an idle cycle with no accept.
   assign rf_we    = (state == ST_FLAGS) || (ld_en && (state == ST_IDLE) && !accept);
   assign rf_waddr = (state == ST_FLAGS) ? rd_q : ld_addr;
   assign rf_wdata = (state == ST_FLAGS) ? result_q : ld_data;

   alu_regfile #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .ra_addr  (instr_ra),
      .ra_data  (ra_data),
      .rb_addr  (instr_rb),
      .rb_data  (rb_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (accept && legal) state_nx = ST_ISSUE;
         ST_ISSUE:  state_nx = ST_RESULT;
         ST_RESULT: state_nx = ST_FLAGS;
         ST_FLAGS:  state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // The ALU computes on every edge, so the opcode falls back to HOLD_OP after one ISSUE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= '0;
         rd_q       <= '0;
         result_q   <= '0;
         alu_opcode <= HOLD_OP;
         alu_a      <= '0;
         alu_b      <= '0;
         flag_c     <= 1'b0;
         flag_z     <= 1'b0;
         flag_s     <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         alu_opcode <= HOLD_OP;
         illegal_op <= accept && !legal;
         case (state)
            ST_IDLE: begin
               if (accept && legal) begin
                  op_q       <= instr_op;
                  rd_q       <= instr_rd;
                  alu_opcode <= instr_op;
                  alu_a      <= ra_data;
                  alu_b      <= rb_data;
               end
            end
            ST_RESULT: begin
               result_q <= alu_out;
               if (op_is_arith(op_q)) flag_c <= alu_carry;
            end
            ST_FLAGS: begin
               flag_z <= alu_zero;
               flag_s <= alu_sign;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_RETIRE_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   retire_cnt <= '0;
      else if (state == ST_FLAGS) retire_cnt <= retire_cnt + 16'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and architectural reference model.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [4:0]  instr_op = '0;
   logic [2:0]  instr_rd = '0, instr_ra = '0, instr_rb = '0;
   logic        ld_en = 1'b0;
   logic [2:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;
   logic        alu_enable;
   logic [4:0]  alu_opcode;
   logic [15:0] alu_a, alu_b;
   logic [15:0] alu_res;
   logic        alu_c, alu_zr, alu_sg;
   logic        flag_c, flag_z, flag_s, done, illegal_op;
   logic [2:0]  dbg_addr = '0;
   logic [15:0] dbg_data;
`ifdef ALU_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Architectural reference state
   logic [15:0] rf_m [8];
   logic        fc, fz, fs;
   logic [4:0]  legal_ops [9] = '{OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC,
                                  OP_AND, OP_OR, OP_XOR, OP_NOT};

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_res), .alu_carry(alu_c), .alu_zero(alu_zr), .alu_sign(alu_sg),
      .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
      .done(done), .illegal_op(illegal_op),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_RETIRE_CNT_EN
      , .retire_cnt(retire_cnt)
`endif
   );

   function automatic logic is_legal(input logic [4:0] op);
      return op inside {OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT};
   endfunction

   function automatic logic is_arith(input logic [4:0] op);
      return op inside {OP_ADD, OP_ADC, OP_SUB, OP_INC, OP_DEC};
   endfunction

   // {carry, result}; carry of SUB/DEC is the borrow, logic ops pass carry-in through.
   function automatic logic [16:0] alu_fn(input logic [4:0] op, input logic [15:0] a, b,
                                          input logic cin);
      case (op)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_ADC:  return {1'b0, a} + {1'b0, b} + {16'h0, cin};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_INC:  return {1'b0, a} + 17'd1;
         OP_DEC:  return {1'b0, a} - 17'd1;
         OP_AND:  return {cin, a & b};
         OP_OR:   return {cin, a | b};
         OP_XOR:  return {cin, a ^ b};
         OP_NOT:  return {cin, ~a};
         default: return {cin, 16'h0};
      endcase
   endfunction

   // Behavioural ALU: result/carry one cycle after presentation, zero/sign one cycle later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_res <= '0; alu_c <= 1'b0; alu_zr <= 1'b0; alu_sg <= 1'b0;
      end else begin
         if (is_legal(alu_opcode)) {alu_c, alu_res} <= alu_fn(alu_opcode, alu_a, alu_b, alu_c);
         alu_zr <= (alu_res == 16'h0);
         alu_sg <= alu_res[15];
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) rf_m[i] = '0;
      fc = 1'b0; fz = 1'b0; fs = 1'b0;
   endtask

   task automatic check_rf(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         total++;
         if (dbg_data !== rf_m[i]) begin
            bad++;
            $display("FAIL %s_rf[%0d]: got %h want %h", tag, i, dbg_data, rf_m[i]);
         end
      end
   endtask

   task automatic load(input logic [2:0] addr, input logic [15:0] data);
      ld_en = 1'b1; ld_addr = addr; ld_data = data;
      @(posedge clk); #1;
      ld_en = 1'b0;
      rf_m[addr] = data;
   endtask

   // ldm: 0 no load, 1 load coinciding with accept, 2 load during ISSUE (both must be dropped)
   task automatic issue(input logic [4:0] op, input logic [2:0] rd, ra, rb, input int ldm);
      logic [15:0] a_exp, b_exp, old_rd;
      logic [16:0] r;
      logic [20:0] alu_prev;
      int          waits = 0;
      while (instr_ready !== 1'b1 && waits < 10) begin
         @(posedge clk); #1; waits++;
      end
      total++;
      if (instr_ready !== 1'b1) begin
         bad++; $display("FAIL ready_wait: instr_ready=%b want 1", instr_ready);
      end
      a_exp = rf_m[ra]; b_exp = rf_m[rb]; old_rd = rf_m[rd];
      alu_prev = {alu_opcode, alu_a};
      dbg_addr = rd;
      instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
      if (ldm == 1) begin
         ld_en = 1'b1; ld_addr = 3'($urandom_range(0, 7)); ld_data = 16'($urandom);
      end
      @(posedge clk); #1;
      instr_valid = 1'b0; ld_en = 1'b0;
      if (!is_legal(op)) begin
         total++;
         if ({illegal_op, instr_ready, alu_enable, alu_opcode, alu_a} !== {3'b110, alu_prev}) begin
            bad++;
            $display("FAIL illegal_accept: ill/rdy/en/op/a=%b%b%b/%h/%h want 110/%h",
                     illegal_op, instr_ready, alu_enable, alu_opcode, alu_a, alu_prev);
         end
         @(posedge clk); #1;
         total++;
         if ({illegal_op, instr_ready} !== 2'b01) begin
            bad++; $display("FAIL illegal_pulse_end: ill/rdy=%b%b want 01", illegal_op, instr_ready);
         end
         return;
      end
      total++;
      if ({alu_enable, alu_opcode, alu_a, alu_b, instr_ready, done, illegal_op}
          !== {1'b1, op, a_exp, b_exp, 3'b000}) begin
         bad++;
         $display("FAIL issue_cycle: en=%b op=%h a=%h b=%h rdy=%b done=%b ill=%b want 1 %h %h %h 0 0 0",
                  alu_enable, alu_opcode, alu_a, alu_b, instr_ready, done, illegal_op, op, a_exp, b_exp);
      end
      if (ldm == 2) begin
         ld_en = 1'b1; ld_addr = 3'($urandom_range(0, 7)); ld_data = 16'($urandom);
      end
      @(posedge clk); #1;
      ld_en = 1'b0;
      total++;
      if ({alu_enable, alu_opcode, done} !== {1'b0, OP_HOLD, 1'b0}) begin
         bad++;
         $display("FAIL result_cycle: en=%b op=%h done=%b want 0 %h 0", alu_enable, alu_opcode, done, OP_HOLD);
      end
      r = alu_fn(op, a_exp, b_exp, fc);
      if (is_arith(op)) fc = r[16];
      @(posedge clk); #1;
      total++;
      if ({done, alu_opcode, flag_c, dbg_data} !== {1'b1, OP_HOLD, fc, old_rd}) begin
         bad++;
         $display("FAIL flags_cycle: done=%b op=%h c=%b dbg=%h want 1 %h %b %h",
                  done, alu_opcode, flag_c, dbg_data, OP_HOLD, fc, old_rd);
      end
      rf_m[rd] = r[15:0]; fz = (r[15:0] == 16'h0); fs = r[15];
      @(posedge clk); #1;
      total++;
      if ({done, instr_ready, dbg_data, flag_c, flag_z, flag_s} !== {2'b01, rf_m[rd], fc, fz, fs}) begin
         bad++;
         $display("FAIL writeback op=%h rd=%0d: done=%b rdy=%b R=%h czs=%b%b%b want 0 1 %h %b%b%b",
                  op, rd, done, instr_ready, dbg_data, flag_c, flag_z, flag_s, rf_m[rd], fc, fz, fs);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      total++;
      if ({instr_ready, alu_enable, alu_opcode, alu_a, alu_b, done, illegal_op, flag_c, flag_z, flag_s}
          !== {2'b00, OP_HOLD, 32'h0, 5'b00000}) begin
         bad++;
         $display("FAIL reset_outputs: rdy=%b en=%b op=%h a=%h b=%h done=%b ill=%b czs=%b%b%b",
                  instr_ready, alu_enable, alu_opcode, alu_a, alu_b, done, illegal_op, flag_c, flag_z, flag_s);
      end
      rst = 1'b0;
      #1;
      total++;
      if (instr_ready !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready: got %b want 1", instr_ready);
      end
      check_rf("reset");
   endtask

   task automatic test_directed();
      load(3'd1, 16'h0003); load(3'd2, 16'h0005);
      issue(OP_ADD, 3'd3, 3'd1, 3'd2, 0);
      dbg_addr = 3'd3; #1;
      total++;
      if ({dbg_data, flag_c, flag_z, flag_s} !== {16'h0008, 3'b000}) begin
         bad++; $display("FAIL add_3_5: R3=%h czs=%b%b%b want 0008 000", dbg_data, flag_c, flag_z, flag_s);
      end
      load(3'd1, 16'hFFFF); load(3'd2, 16'h0001);
      issue(OP_ADD, 3'd4, 3'd1, 3'd2, 0);
      dbg_addr = 3'd4; #1;
      total++;
      if ({dbg_data, flag_c, flag_z} !== {16'h0000, 2'b11}) begin
         bad++; $display("FAIL add_wrap: R4=%h cz=%b%b want 0000 11", dbg_data, flag_c, flag_z);
      end
      issue(OP_AND, 3'd5, 3'd1, 3'd1, 0);
      dbg_addr = 3'd5; #1;
      total++;
      if ({dbg_data, flag_c} !== {16'hFFFF, 1'b1}) begin
         bad++; $display("FAIL and_keeps_c: R5=%h c=%b want ffff 1", dbg_data, flag_c);
      end
      load(3'd1, 16'h0002); load(3'd2, 16'h0003);
      issue(OP_ADC, 3'd6, 3'd1, 3'd2, 0);
      dbg_addr = 3'd6; #1;
      total++;
      if (dbg_data !== 16'h0006) begin
         bad++; $display("FAIL adc_once: R6=%h want 0006", dbg_data);
      end
      check_rf("directed");
   endtask

   task automatic test_back_to_back();
      logic [7:0] rdy_seen, done_seen, rdy_exp, done_exp;
      logic [15:0] r7_mid, r7_end;
      load(3'd7, 16'h0000);
      dbg_addr = 3'd7;
      instr_valid = 1'b1; instr_op = OP_INC; instr_rd = 3'd7; instr_ra = 3'd7; instr_rb = 3'd0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         rdy_seen[k] = instr_ready; done_seen[k] = done;
         if (k == 3) r7_mid = dbg_data;
         if (k == 4) instr_valid = 1'b0;
      end
      r7_end = dbg_data;
      rdy_exp  = 8'b1000_1000;
      done_exp = 8'b0100_0100;
      total++;
      if ({rdy_seen, done_seen} !== {rdy_exp, done_exp}) begin
         bad++;
         $display("FAIL b2b_timing: ready=%b done=%b want %b %b", rdy_seen, done_seen, rdy_exp, done_exp);
      end
      total++;
      if ({r7_mid, r7_end} !== {16'h0001, 16'h0002}) begin
         bad++; $display("FAIL b2b_values: R7=%h then %h want 0001 then 0002", r7_mid, r7_end);
      end
      rf_m[7] = 16'h0002; fc = 1'b0; fz = 1'b0; fs = 1'b0;
   endtask

   task automatic test_illegal_and_loads();
      logic [2:0] czs;
      czs = {fc, fz, fs};
      issue(5'h1E, 3'd1, 3'd2, 3'd3, 0);
      issue(5'h1E, 3'd4, 3'd4, 3'd4, 1);
      total++;
      if ({flag_c, flag_z, flag_s} !== czs) begin
         bad++; $display("FAIL illegal_flags: czs=%b%b%b want %b", flag_c, flag_z, flag_s, czs);
      end
      issue(OP_XOR, 3'd0, 3'd1, 3'd2, 2);
      issue(OP_SUB, 3'd1, 3'd0, 3'd6, 1);
      check_rf("illegal_loads");
   endtask

   task automatic test_random();
      logic [4:0] op;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 2) == 0) load(3'($urandom_range(0, 7)), 16'($urandom));
         op = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(9, 31)) : legal_ops[$urandom_range(0, 8)];
         issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 2)));
      end
      check_rf("random");
   endtask

   task automatic test_reset_mid();
      int done_cnt = 0;
      load(3'd1, 16'h0009); load(3'd3, 16'h0004); load(3'd2, 16'h0000);
      dbg_addr = 3'd2;
      instr_valid = 1'b1; instr_op = OP_SUB; instr_rd = 3'd2; instr_ra = 3'd1; instr_rb = 3'd3;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      #1;
      total++;
      if ({instr_ready, done, alu_opcode} !== {2'b00, OP_HOLD}) begin
         bad++; $display("FAIL mid_reset_hold: rdy=%b done=%b op=%h want 0 0 %h", instr_ready, done, alu_opcode, OP_HOLD);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      total++;
      if (instr_ready !== 1'b1) begin
         bad++; $display("FAIL mid_reset_ready: got %b want 1", instr_ready);
      end
      for (int k = 0; k < 5; k++) begin
         if (done === 1'b1) done_cnt++;
         @(posedge clk); #1;
      end
      total++;
      if ({done_cnt, dbg_data, flag_c, flag_z, flag_s} !== {32'd0, 16'h0000, 3'b000}) begin
         bad++; $display("FAIL mid_reset_abandon: done_pulses=%0d R2=%h czs=%b%b%b want 0 0000 000",
                         done_cnt, dbg_data, flag_c, flag_z, flag_s);
      end
      check_rf("mid_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_illegal_and_loads();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
